imsic_msi_rx: RTL and testbench
===============================

// Module: imsic_msi_rx
// PURPOSE
//  - Receiving end of the APLIC MSI delivery path: accepts MSI writes from the APLIC
//    (MSI delivery mode) or the genmsi path, and sets pending bits in IMSIC interrupt files.
//  - Decodes target file (M/S) from the write address and the EIID from write data.
//  - Buffers messages in a small FIFO, maintains eip bits, computes a registered topei per file.
// PARAMETERS
//  - NrIntpFiles   2             interrupt files; index 0 = M, index 1 = S
//  - NrSourcesImsic 64           EIIDs per file; valid EIID range 1..NrSourcesImsic-1
//  - FifoDepth     4             message FIFO entries (power of 2, >=2)
//  - MBaseAddr     32'h2400_0000 4 KiB-aligned base of the M file page
//  - SBaseAddr     32'h2800_0000 4 KiB-aligned base of the S file page
// PORTS
//  - i_clk          in   1                        clock
//  - ni_rst         in   1                        async reset, active-low
//  - i_msi_valid    in   1                        MSI write request valid
//  - o_msi_ready    out  1                        request accepted when valid&ready
//  - i_msi_addr     in   32                       MSI write address
//  - i_msi_data     in   32                       MSI write data
//  - o_msi_drop     out  1                        1-cycle pulse: accepted write discarded
//  - i_eie          in   NrIntpFiles*NrSourcesImsic  enable bits per file
//  - i_eithreshold  in   NrIntpFiles*11           threshold per file (0 = none)
//  - i_claim        in   NrIntpFiles              claim strobe per file (clears topei's eip)
//  - o_eip          out  NrIntpFiles*NrSourcesImsic  pending bits
//  - o_topei        out  NrIntpFiles*11           highest-priority pending+enabled EIID, 0 = none
//  - o_xeip         out  NrIntpFiles              o_topei[f] != 0
// BEHAVIOUR
//  - Reset: o_eip=0, o_topei=0, o_xeip=0, o_msi_drop=0, FIFO empty, o_msi_ready=1.
//  - Handshake: o_msi_ready = !fifo_full; valid may not drop before ready; data is sampled on the accept edge.
//  - Decode at accept: file f matches when addr[31:12]==base_f[31:12]; offset addr[11:0]
//    0x000 = seteipnum_le, eiid=data[10:0]; any other offset -> drop.
//  - Drop (accepted, not enqueued, o_msi_drop=1 next cycle): no file match, bad offset,
//    eiid==0, eiid>=NrSourcesImsic, or data[31:11]!=0.
//  - FIFO: entry {file, eiid}; push on accept of a valid message; pop one entry/cycle when non-empty.
//    Full: ready=0. Push+pop same cycle when full is impossible (ready=0); pop on empty is a no-op.
//  - Latency: accept at N -> pop at N+1 -> eip set visible N+2 -> o_topei/o_xeip updated N+3.
//  - topei[f] (registered): lowest EIID i with eip&eie; when threshold!=0, only i<threshold qualifies; else 0.
//  - Claim: i_claim[f] clears eip[f][o_topei[f]] next edge; no-op when o_topei[f]==0.
//    Claim and pop set the same bit in one cycle: set wins (new message retained).
//  - Duplicate messages to an already-pending EIID merge (bit stays 1).
//  - Async reset mid-operation empties the FIFO and discards in-flight messages.
// CONFIGURATION
//  - IMSIC_SETEIPNUM_BE_EN defined: offset 0x004 = seteipnum_be; data byte-swapped before
//    decode. Undefined: 0x004 -> drop.
// STRUCTURE
//  - Shared package imsic_pkg: SETEIPNUM_LE_OFF='h000, SETEIPNUM_BE_OFF='h004, imsic_eiid_t
//    (logic[10:0]), imsic_msg_t packed {file idx, imsic_eiid_t}, file indices M=0/S=1.
//  - Sub-module imsic_msi_fifo: parameterised sync FIFO (push/pop/full/empty, ptr wrap-around).
// TESTING
//  - Write 0x2400_0000 data 5, eie[M][5]=1 -> eip[M][5]=1 at N+2, topei[M]=5, xeip[M]=1 at N+3.
//  - Write 0x2800_0000 data 0, data 64, addr 0x2C00_0000 -> 3 drop pulses, eip unchanged.
//  - Writes EIID 9, then 3 (S, all enabled), threshold 0 -> topei=3; claim -> topei=9.
//  - Threshold=4, pending 3 and 7 -> topei=3; threshold=3 -> topei=0, xeip=0.
//  - Hold pop path busy by sending 6 back-to-back writes -> ready deasserts only when
//    FIFO full, no message lost, all 6 bits set.
//  - BE_EN: write 0x2400_0004 data 32'h0A00_0000 -> eip[M][10]=1; without macro -> drop pulse.
//  - Claim EIID 5 in same cycle as pop of EIID 5 -> eip[5] stays 1; ni_rst low mid-burst -> all cleared.

Source files
------------

// File: rtl/imsic_pkg.sv
// Shared IMSIC types: MSI register offsets, EIID/file-index types and the queued message format.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imsic_pkg;

  localparam logic [11:0] SETEIPNUM_LE_OFF = 12'h000;
  localparam logic [11:0] SETEIPNUM_BE_OFF = 12'h004;

  localparam int IMSIC_EIID_W = 11;

  typedef logic [IMSIC_EIID_W-1:0] imsic_eiid_t;
  typedef logic [0:0]              imsic_file_t;

  localparam imsic_file_t IMSIC_FILE_M = 1'b0;
  localparam imsic_file_t IMSIC_FILE_S = 1'b1;

  typedef struct packed {
    imsic_file_t file;
    imsic_eiid_t eiid;
  } imsic_msg_t;

  // Byte reversal used by the big-endian seteipnum register.
  function automatic logic [31:0] imsic_bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; pop_dat shows the head entry combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: full blocks pushes, empty blocks pops; an ignored request is a no-op.
module imsic_msi_fifo #(
  parameter int Width = 12,
  parameter int Depth = 4
) (
  input  logic             i_clk,
  input  logic             ni_rst,
  input  logic             push_vld,
  input  logic [Width-1:0] push_dat,
  input  logic             pop_vld,
  output logic [Width-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Equal indices with differing wrap bits means the write side lapped the read side.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // Pointer advance; requests against full/empty are ignored.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_vld && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (push_vld && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/imsic_msi_rx.sv
// MSI receive path: decodes seteipnum writes into {file, eiid}, queues them, sets eip and computes topei.
// Latency: accept N -> FIFO pop N+1 -> eip visible N+2 -> topei/xeip visible N+3; bad writes pulse drop at N+1.
// Backpressure: o_msi_ready drops only while the FIFO is full. IMSIC_SETEIPNUM_BE_EN enables offset 0x004 (byte-swapped data).
module imsic_msi_rx import imsic_pkg::*; #(
  parameter int          NrIntpFiles    = 2,
  parameter int          NrSourcesImsic = 64,
  parameter int          FifoDepth      = 4,
  parameter logic [31:0] MBaseAddr      = 32'h2400_0000,
  parameter logic [31:0] SBaseAddr      = 32'h2800_0000
) (
  input  logic                                  i_clk,
  input  logic                                  ni_rst,
  input  logic                                  i_msi_valid,
  output logic                                  o_msi_ready,
  input  logic [31:0]                           i_msi_addr,
  input  logic [31:0]                           i_msi_data,
  output logic                                  o_msi_drop,
  input  logic [NrIntpFiles*NrSourcesImsic-1:0] i_eie,
  input  logic [NrIntpFiles*IMSIC_EIID_W-1:0]   i_eithreshold,
  input  logic [NrIntpFiles-1:0]                i_claim,
  output logic [NrIntpFiles*NrSourcesImsic-1:0] o_eip,
  output logic [NrIntpFiles*IMSIC_EIID_W-1:0]   o_topei,
  output logic [NrIntpFiles-1:0]                o_xeip
);

  localparam int EW = IMSIC_EIID_W;
  localparam int NS = NrSourcesImsic;

  logic [11:0] wr_off;
  logic [31:0] wr_dat;
  logic        off_ok;
  logic        match_m;
  logic        match_s;
  logic        msg_ok;
  logic        accept;
  logic        push_vld;
  logic        pop_vld;
  logic        fifo_full;
  logic        fifo_empty;
  imsic_msg_t  push_msg;
  imsic_msg_t  pop_msg;
  logic [$bits(imsic_msg_t)-1:0] pop_raw;

  logic [NrIntpFiles*NS-1:0] eip_q;
  logic [NrIntpFiles*NS-1:0] eip_nxt;
  logic [NrIntpFiles*EW-1:0] topei_q;
  logic [NrIntpFiles*EW-1:0] topei_nxt;
  logic                      drop_q;

  // Decode the write into a message and decide whether it is deliverable.
  always_comb begin
    wr_off = i_msi_addr[11:0];
    wr_dat = i_msi_data;
    off_ok = (wr_off == SETEIPNUM_LE_OFF);
`ifdef IMSIC_SETEIPNUM_BE_EN
    if (wr_off == SETEIPNUM_BE_OFF) begin
      wr_dat = imsic_bswap32(i_msi_data);
      off_ok = 1'b1;
    end
`endif
    match_m       = (i_msi_addr[31:12] == MBaseAddr[31:12]);
    match_s       = (i_msi_addr[31:12] == SBaseAddr[31:12]);
    push_msg.file = match_m ? IMSIC_FILE_M : IMSIC_FILE_S;
    push_msg.eiid = wr_dat[EW-1:0];
    msg_ok = (match_m || match_s) && off_ok && (wr_dat[31:EW] == '0) &&
             (push_msg.eiid != '0) && (push_msg.eiid < imsic_eiid_t'(NS));
  end

  assign o_msi_ready = !fifo_full;
  assign accept      = i_msi_valid && o_msi_ready;
  assign push_vld    = accept && msg_ok;
  // Drain one message every cycle the queue holds one.
  assign pop_vld     = !fifo_empty;
  assign pop_msg     = imsic_msg_t'(pop_raw);

  imsic_msi_fifo #(
    .Width ($bits(imsic_msg_t)),
    .Depth (FifoDepth)
  ) u_fifo (
    .i_clk    (i_clk),
    .ni_rst   (ni_rst),
    .push_vld (push_vld),
    .push_dat (push_msg),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_raw),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Next pending state: claim clears first so a same-cycle pop of that EIID re-sets it.
  always_comb begin
    eip_nxt = eip_q;
    for (int f = 0; f < NrIntpFiles; f++) begin
      if (i_claim[f] && (topei_q[f*EW +: EW] != '0))
        eip_nxt[f*NS + int'(topei_q[f*EW +: EW])] = 1'b0;
    end
    if (pop_vld)
      eip_nxt[int'(pop_msg.file)*NS + int'(pop_msg.eiid)] = 1'b1;
  end

  // Lowest enabled pending EIID under threshold; scanning downward leaves the lowest hit.
  always_comb begin
    topei_nxt = '0;
    for (int f = 0; f < NrIntpFiles; f++) begin
      for (int i = NS-1; i >= 0; i--) begin
        if (eip_q[f*NS+i] && i_eie[f*NS+i] &&
            ((i_eithreshold[f*EW +: EW] == '0) || (imsic_eiid_t'(i) < i_eithreshold[f*EW +: EW])))
          topei_nxt[f*EW +: EW] = imsic_eiid_t'(i);
      end
    end
  end

  // State registers: pending bits, registered topei and the drop pulse.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      eip_q   <= '0;
      topei_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      eip_q   <= eip_nxt;
      topei_q <= topei_nxt;
      drop_q  <= accept && !msg_ok;
    end
  end

  // External interrupt line per file follows the registered topei.
  always_comb begin
    o_xeip = '0;
    for (int f = 0; f < NrIntpFiles; f++) o_xeip[f] = |topei_q[f*EW +: EW];
  end

  assign o_eip      = eip_q;
  assign o_topei    = topei_q;
  assign o_msi_drop = drop_q;

endmodule

// File: tb/tb_imsic_msi_rx.sv
// Bench for imsic_msi_rx: queue/array model checked every cycle plus hand-computed literal checks.
// Latency: model applies accept->eip +2 edges and eip->topei +1 edge behaviourally.
// Backpressure: writes hold valid until ready is seen, bounded by a cycle budget.
module tb_imsic_msi_rx;

  localparam int DEPTH = 4;

  logic         i_clk = 1'b0;
  logic         ni_rst = 1'b1;
  logic         i_msi_valid = 1'b0;
  logic         o_msi_ready;
  logic [31:0]  i_msi_addr = '0;
  logic [31:0]  i_msi_data = '0;
  logic         o_msi_drop;
  logic [127:0] i_eie = '1;
  logic [21:0]  i_eithreshold = '0;
  logic [1:0]   i_claim = '0;
  logic [127:0] o_eip;
  logic [21:0]  o_topei;
  logic [1:0]   o_xeip;

  imsic_msi_rx dut (
    .i_clk         (i_clk),
    .ni_rst        (ni_rst),
    .i_msi_valid   (i_msi_valid),
    .o_msi_ready   (o_msi_ready),
    .i_msi_addr    (i_msi_addr),
    .i_msi_data    (i_msi_data),
    .o_msi_drop    (o_msi_drop),
    .i_eie         (i_eie),
    .i_eithreshold (i_eithreshold),
    .i_claim       (i_claim),
    .o_eip         (o_eip),
    .o_topei       (o_topei),
    .o_xeip        (o_xeip)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  int drops_seen = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int f; int e; } mmsg_t;
  logic [63:0] m_eip [2];
  int          m_topei [2];
  int          nt [2];
  bit          m_drop;
  mmsg_t       m_q [$];
  mmsg_t       pm;
  int          qs, thr, mf, me;

  // Target file from the 4 KiB page, EIID from (optionally swapped) data; 0 = not deliverable.
  function automatic bit decode(input logic [31:0] a, input logic [31:0] d, output int f, output int e);
    logic [31:0] v;
    int off;
    v = d;
    off = int'(a[11:0]);
    f = -1;
    e = 0;
    if (a[31:12] == 20'h24000) f = 0;
    else if (a[31:12] == 20'h28000) f = 1;
`ifdef IMSIC_SETEIPNUM_BE_EN
    if (off == 4) begin
      v = {d[7:0], d[15:8], d[23:16], d[31:24]};
      off = 0;
    end
`endif
    if (f < 0 || off != 0 || v == 0 || v >= 64) return 1'b0;
    e = int'(v);
    return 1'b1;
  endfunction

  always @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      m_eip[0] = '0; m_eip[1] = '0;
      m_topei[0] = 0; m_topei[1] = 0;
      m_q.delete();
      m_drop = 1'b0;
    end else begin
      qs = m_q.size();
      for (int f = 0; f < 2; f++) begin
        thr = int'(i_eithreshold[f*11 +: 11]);
        nt[f] = 0;
        for (int i = 1; i < 64; i++) begin
          if (m_eip[f][i] && i_eie[f*64+i] && (thr == 0 || i < thr)) begin
            nt[f] = i;
            break;
          end
        end
      end
      for (int f = 0; f < 2; f++)
        if (i_claim[f] && m_topei[f] != 0) m_eip[f][m_topei[f]] = 1'b0;
      if (qs > 0) begin
        pm = m_q.pop_front();
        m_eip[pm.f][pm.e] = 1'b1;
      end
      m_drop = 1'b0;
      if (i_msi_valid && qs < DEPTH) begin
        if (decode(i_msi_addr, i_msi_data, mf, me)) m_q.push_back('{f: mf, e: me});
        else m_drop = 1'b1;
      end
      m_topei[0] = nt[0];
      m_topei[1] = nt[1];
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("eip", 128'(o_eip), {m_eip[1], m_eip[0]});
      check("topei", 128'(o_topei), 128'({11'(m_topei[1]), 11'(m_topei[0])}));
      check("xeip", 128'(o_xeip), 128'({m_topei[1] != 0, m_topei[0] != 0}));
      check("drop", 128'(o_msi_drop), 128'(m_drop));
      check("ready", 128'(o_msi_ready), 128'(m_q.size() < DEPTH));
      if (o_msi_drop === 1'b1) drops_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  // Present a write and hold it until accepted; leaves valid high for back-to-back use.
  task automatic send(input logic [31:0] a, input logic [31:0] d);
    logic r;
    int n;
    i_msi_valid = 1'b1;
    i_msi_addr  = a;
    i_msi_data  = d;
    n = 0;
    forever begin
      @(negedge i_clk);
      r = o_msi_ready;
      @(posedge i_clk);
      #2;
      if (r === 1'b1) return;
      n++;
      if (n > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: ready=%b, expected 1 within 50 cycles", r);
        return;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    #1 ni_rst = 1'b0;
    #1 chk_en = 1'b1;
    #21 ni_rst = 1'b1;
    tick(1);
    check("reset_eip", 128'(o_eip), 128'd0);
    check("reset_ready", 128'(o_msi_ready), 128'd1);

    // Single M write of EIID 5: eip after one more edge, topei after two.
    send(32'h2400_0000, 32'd5);
    i_msi_valid = 1'b0;
    tick(1);
    check("lat_eip_m5", 128'(o_eip[5]), 128'd1);
    check("lat_topei_early", 128'(o_topei[10:0]), 128'd0);
    tick(1);
    check("lat_topei_m", 128'(o_topei[10:0]), 128'd5);
    check("lat_xeip_m", 128'(o_xeip[0]), 128'd1);

    // Three undeliverable writes.
    d0 = drops_seen;
    send(32'h2800_0000, 32'd0);
    send(32'h2800_0000, 32'd64);
    send(32'h2C00_0000, 32'd5);
    i_msi_valid = 1'b0;
    tick(3);
    check("drop_count", 128'(drops_seen - d0), 128'd3);
    check("drop_s_eip", 128'(o_eip[127:64]), 128'd0);

    // S: 9 then 3, topei picks lowest; claim removes 3.
    send(32'h2800_0000, 32'd9);
    send(32'h2800_0000, 32'd3);
    i_msi_valid = 1'b0;
    tick(2);
    check("s_topei_3", 128'(o_topei[21:11]), 128'd3);
    i_claim = 2'b10;
    tick(1);
    i_claim = 2'b00;
    tick(1);
    check("s_topei_9", 128'(o_topei[21:11]), 128'd9);

    // Threshold on S with 3, 7, 9 pending.
    send(32'h2800_0000, 32'd3);
    send(32'h2800_0000, 32'd7);
    i_msi_valid = 1'b0;
    tick(3);
    i_eithreshold[21:11] = 11'd4;
    tick(2);
    check("thr4_topei", 128'(o_topei[21:11]), 128'd3);
    i_eithreshold[21:11] = 11'd3;
    tick(2);
    check("thr3_topei", 128'(o_topei[21:11]), 128'd0);
    check("thr3_xeip", 128'(o_xeip[1]), 128'd0);
    i_eithreshold = '0;
    tick(2);

    // Six back-to-back M writes.
    for (int k = 20; k < 26; k++) send(32'h2400_0000, 32'(k));
    i_msi_valid = 1'b0;
    tick(3);
    check("burst_bits", 128'(o_eip[25:20]), 128'h3f);

    // Big-endian register.
    send(32'h2400_0004, 32'h0A00_0000);
    i_msi_valid = 1'b0;
    @(negedge i_clk);
`ifdef IMSIC_SETEIPNUM_BE_EN
    check("be_drop", 128'(o_msi_drop), 128'd0);
`else
    check("be_drop", 128'(o_msi_drop), 128'd1);
`endif
    @(posedge i_clk);
    #2;
    tick(2);
`ifdef IMSIC_SETEIPNUM_BE_EN
    check("be_eip10", 128'(o_eip[10]), 128'd1);
`else
    check("be_eip10", 128'(o_eip[10]), 128'd0);
`endif

    // Claim of EIID 5 on the same edge its re-sent message pops.
    send(32'h2400_0000, 32'd5);
    i_msi_valid = 1'b0;
    i_claim = 2'b01;
    tick(1);
    i_claim = 2'b00;
    tick(2);
    check("claim_pop_eip5", 128'(o_eip[5]), 128'd1);
    check("claim_pop_topei", 128'(o_topei[10:0]), 128'd5);

    // Reset while messages are in flight.
    send(32'h2400_0000, 32'd30);
    send(32'h2400_0000, 32'd31);
    #1;
    ni_rst = 1'b0;
    i_msi_valid = 1'b0;
    tick(2);
    check("rst_eip", 128'(o_eip), 128'd0);
    check("rst_topei", 128'(o_topei), 128'd0);
    #1 ni_rst = 1'b1;
    tick(4);
    check("rst_inflight", 128'(o_eip[31:30]), 128'd0);
    check("rst_eip_after", 128'(o_eip), 128'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
